fa_exhaustive_checker: RTL and testbench



---
 rtl/fa_exhaustive_checker.sv | 118 +++++++++++
 tb/tb_fa_exhaustive_checker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fa_exhaustive_checker.sv
// rtl/fa_exhaustive_checker.sv - exhaustive BIST engine for a 1-bit full adder
// Walks all eight {a,b,c_in} vectors, waits SETTLE+1 cycles each, then scores sum/carry.
module fa_exhaustive_checker #(
  parameter int SETTLE = 2,
  parameter int ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             c_in,
  input  logic             sum,
  input  logic             carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [2:0]       fail_vec
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_e;

  state_e           state_q;
  logic [2:0]       vec_q;
  logic [3:0]       cnt_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic             fail_valid_q;
  logic [2:0]       fail_vec_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             exp_sum;
  logic             exp_carry;
  logic             mismatch;

  // Case inequality so an undriven or X response from the adder scores as a failure.
  always_comb begin
    exp_sum   = vec_q[2] ^ vec_q[1] ^ vec_q[0];
    exp_carry = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
    mismatch  = (sum !== exp_sum) || (carry !== exp_carry);
    err_d     = err_q;
    if (mismatch && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q      <= S_WAIT;
            vec_q        <= '0;
            cnt_q        <= SETTLE_C;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_CHECK: begin
          err_q <= err_d;
          if (mismatch && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_vec_q   <= vec_q;
          end
          if (vec_q == 3'd7) begin
            state_q <= S_DONE;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            state_q <= S_WAIT;
            vec_q   <= vec_q + 3'd1;
            cnt_q   <= SETTLE_C;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign a          = vec_q[2];
  assign b          = vec_q[1];
  assign c_in       = vec_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_fa_exhaustive_checker.sv
// tb/tb_fa_exhaustive_checker.sv - self-checking bench for fa_exhaustive_checker
// Three instances (SETTLE=2/ERR_W=4, SETTLE=0/ERR_W=4, SETTLE=2/ERR_W=2) share clock, reset and start.
module tb_fa_exhaustive_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] smask = 8'h00;
  logic [7:0] cmask = 8'h00;

  logic [2:0] va_w   [3];
  logic [3:0] err_w  [3];
  logic [2:0] fvec_w [3];
  logic [2:0] busy_w;
  logic [2:0] done_w;
  logic [2:0] pass_w;
  logic [2:0] fv_w;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;
  int has_run [3];
  int s_edge  [3];

  always #5 clk = ~clk;

  // Adder under test: correct arithmetic with per-vector flips on sum/carry selected by the masks.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int S = (g == 1) ? 0 : 2;
    localparam int W = (g == 2) ? 2 : 4;
    logic         xa, xb, xc;
    logic [1:0]   resp;
    logic [W-1:0] xe;
    assign resp = (2'(xa) + 2'(xb) + 2'(xc)) ^ {cmask[{xa, xb, xc}], smask[{xa, xb, xc}]};
    fa_exhaustive_checker #(.SETTLE(S), .ERR_W(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (xa),
      .b         (xb),
      .c_in      (xc),
      .sum       (resp[0]),
      .carry     (resp[1]),
      .busy      (busy_w[g]),
      .done      (done_w[g]),
      .pass      (pass_w[g]),
      .err_cnt   (xe),
      .fail_valid(fv_w[g]),
      .fail_vec  (fvec_w[g])
    );
    assign va_w[g]   = {xa, xb, xc};
    assign err_w[g]  = 4'(xe);
  end

  function automatic int set_of(input int i);
    return (i == 1) ? 0 : 2;
  endfunction

  function automatic int ew_of(input int i);
    return (i == 2) ? 2 : 4;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, edge_n, act, exp);
    end
  endtask

  // Reference: from the accepted start edge, vector n occupies cycles n*(S+2)..n*(S+2)+S+1
  // and is scored when that window ends; results are counts over the faulty vectors seen so far.
  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int per, len, r, nchk, cnt, first, ev, eb, ed, emax;
      per = set_of(i) + 2;
      len = 8 * per;
      emax = (1 << ew_of(i)) - 1;
      ev = 0; eb = 0; ed = 0; cnt = 0; first = -1;
      if (has_run[i] != 0) begin
        r = edge_n - s_edge[i];
        nchk = (r / per > 8) ? 8 : r / per;
        if (r < len) begin
          ev = r / per;
          eb = 1;
        end else begin
          ed = 1;
        end
        for (int v = 0; v < nchk; v++) begin
          if ((smask[v] | cmask[v]) != 1'b0) begin
            cnt++;
            if (first < 0) first = v;
          end
        end
      end
      chk($sformatf("inst%0d abc", i), int'(va_w[i]), ev);
      chk($sformatf("inst%0d busy", i), int'(busy_w[i]), eb);
      chk($sformatf("inst%0d done", i), int'(done_w[i]), ed);
      chk($sformatf("inst%0d err_cnt", i), int'(err_w[i]), (cnt > emax) ? emax : cnt);
      chk($sformatf("inst%0d fail_valid", i), int'(fv_w[i]), (cnt > 0) ? 1 : 0);
      chk($sformatf("inst%0d fail_vec", i), int'(fvec_w[i]), (first < 0) ? 0 : first);
      chk($sformatf("inst%0d pass", i), int'(pass_w[i]), (ed == 1 && cnt == 0) ? 1 : 0);
    end
  endtask

  task automatic cycle(input logic st);
    start = st;
    @(posedge clk);
    edge_n++;
    for (int i = 0; i < 3; i++) begin
      if (st && rst_n && (has_run[i] == 0 || (edge_n - 1 - s_edge[i]) >= 8 * (set_of(i) + 2))) begin
        has_run[i] = 1;
        s_edge[i]  = edge_n;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  // mode 1 adds extra start pulses 5 and 17 cycles after the accepted start.
  task automatic run(input logic [7:0] sm, input logic [7:0] cm, input int mode);
    smask = sm;
    cmask = cm;
    for (int k = 0; k < 36; k++) begin
      cycle((k == 0) || (mode == 1 && (k == 5 || k == 17)));
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [7:0] sm;
    logic [7:0] cm;
    int         mode;
    int         err;
    int         err2;
    int         fv;
    int         fvec;
    int         ps;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{sm: 8'h00, cm: 8'h00, mode: 0, err: 0, err2: 0, fv: 0, fvec: 0, ps: 1};
    tbl[1] = '{sm: 8'h00, cm: 8'hE8, mode: 0, err: 4, err2: 3, fv: 1, fvec: 3, ps: 0};
    tbl[2] = '{sm: 8'hFF, cm: 8'h00, mode: 0, err: 8, err2: 3, fv: 1, fvec: 0, ps: 0};
    tbl[3] = '{sm: 8'h20, cm: 8'h20, mode: 0, err: 1, err2: 1, fv: 1, fvec: 5, ps: 0};
    tbl[4] = '{sm: 8'h80, cm: 8'h00, mode: 1, err: 1, err2: 1, fv: 1, fvec: 7, ps: 0};
    tbl[5] = '{sm: 8'h00, cm: 8'h00, mode: 1, err: 0, err2: 0, fv: 0, fvec: 0, ps: 1};
    for (int i = 0; i < 3; i++) begin
      has_run[i] = 0;
      s_edge[i]  = 0;
    end

    cycle(1'b0);
    cycle(1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0);

    for (int t = 0; t < 6; t++) begin
      run(tbl[t].sm, tbl[t].cm, tbl[t].mode);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("tbl%0d inst%0d final err_cnt", t, i), int'(err_w[i]), (i == 2) ? tbl[t].err2 : tbl[t].err);
        chk($sformatf("tbl%0d inst%0d final fail_valid", t, i), int'(fv_w[i]), tbl[t].fv);
        chk($sformatf("tbl%0d inst%0d final fail_vec", t, i), int'(fvec_w[i]), tbl[t].fvec);
        chk($sformatf("tbl%0d inst%0d final pass", t, i), int'(pass_w[i]), tbl[t].ps);
        chk($sformatf("tbl%0d inst%0d final done", t, i), int'(done_w[i]), 1);
      end
    end

    for (int t = 0; t < 10; t++) begin
      run(8'($urandom) & 8'($urandom), 8'($urandom) & 8'($urandom), int'($urandom_range(0, 1)));
    end

    smask = 8'h11;
    cmask = 8'h40;
    for (int k = 0; k < 40; k++) cycle(1'b1);
    for (int k = 0; k < 36; k++) cycle(1'b0);

    smask = 8'hFF;
    cmask = 8'h00;
    for (int k = 0; k < 18; k++) cycle(k == 0);
    chk("pre-reset inst0 fail_valid", int'(fv_w[0]), 1);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) has_run[i] = 0;
    #1;
    check_all();
    cycle(1'b0);
    rst_n = 1'b1;
    run(8'h00, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("post-reset inst%0d pass", i), int'(pass_w[i]), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
